// File: rtl/bolme_birimi.sv
// rtl/bolme_birimi.sv - radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional single-entry result cache is enabled with the BOLME_ONBELLEK_EN macro.
module bolme_birimi #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            basla_i,
    input  logic            temizle_i,
    input  logic [1:0]      kontrol_i,
    input  logic [XLEN-1:0] deger1_i,
    input  logic [XLEN-1:0] deger2_i,
    output logic [XLEN-1:0] sonuc_o,
    output logic            mesgul_o,
    output logic            gecerli_o
);
    localparam logic [1:0] BOLME_DIV  = 2'b00;
    localparam logic [1:0] BOLME_DIVU = 2'b01;
    localparam logic [1:0] BOLME_REM  = 2'b10;
    localparam logic [1:0] BOLME_REMU = 2'b11;

    localparam int SW = $clog2(XLEN + 1);
    localparam logic [SW-1:0]   SAYAC_YUK = SW'(XLEN);
    localparam logic [SW-1:0]   SAYAC_BIR = SW'(1);
    localparam logic [XLEN-1:0] EN_KUCUK  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        BOSTA,
        BOL,
        DUZELT
    } durum_t;

    durum_t durum, durum_sonraki;

    logic [1:0]      kontrol_r;
    logic            isaret1_r, isaret2_r, ozel_r;
    logic [XLEN-1:0] bolen_r, kalan_r, bolum_r;
    logic [SW-1:0]   sayac_r;

    logic            isaretli, isaretli_r, bolum_sec_r;
    logic            sifira_bolme, tasma, isabet, kabul;
    logic [XLEN-1:0] mutlak1, mutlak2, bolum_son, kalan_son;
    logic [XLEN:0]   kaydirilmis, fark;

    always_comb begin
        isaretli     = (kontrol_i == BOLME_DIV) || (kontrol_i == BOLME_REM);
        isaretli_r   = (kontrol_r == BOLME_DIV) || (kontrol_r == BOLME_REM);
        bolum_sec_r  = (kontrol_r == BOLME_DIV) || (kontrol_r == BOLME_DIVU);
        mutlak1      = (isaretli && deger1_i[XLEN-1]) ? -deger1_i : deger1_i;
        mutlak2      = (isaretli && deger2_i[XLEN-1]) ? -deger2_i : deger2_i;
        sifira_bolme = (deger2_i == '0);
        tasma        = isaretli && (deger1_i == EN_KUCUK) && (deger2_i == '1);
        kabul        = (durum == BOSTA) && basla_i && !temizle_i && !isabet;
        // Remainder is always below the divisor, so one extra bit holds the shifted value.
        kaydirilmis  = {kalan_r, bolum_r[XLEN-1]};
        fark         = kaydirilmis - {1'b0, bolen_r};
        // Special-case results are preloaded already in final form.
        bolum_son    = (!ozel_r && isaretli_r && (isaret1_r ^ isaret2_r)) ? -bolum_r : bolum_r;
        kalan_son    = (!ozel_r && isaretli_r && isaret1_r) ? -kalan_r : kalan_r;
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOSTA:   if (kabul) durum_sonraki = (sifira_bolme || tasma) ? DUZELT : BOL;
            BOL:     if (sayac_r == SAYAC_BIR) durum_sonraki = DUZELT;
            DUZELT:  durum_sonraki = BOSTA;
            default: durum_sonraki = BOSTA;
        endcase
        if (temizle_i) durum_sonraki = BOSTA;
    end

    assign mesgul_o = (durum != BOSTA);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) durum <= BOSTA;
        else        durum <= durum_sonraki;
    end

`ifdef BOLME_ONBELLEK_EN
    logic            onb_gecerli, onb_isaretli;
    logic [XLEN-1:0] onb_d1, onb_d2, onb_bolum, onb_kalan, deger1_r, deger2_r;

    assign isabet = onb_gecerli && (onb_d1 == deger1_i) && (onb_d2 == deger2_i)
                    && (onb_isaretli == isaretli);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            onb_gecerli  <= 1'b0;
            onb_isaretli <= 1'b0;
            onb_d1       <= '0;
            onb_d2       <= '0;
            onb_bolum    <= '0;
            onb_kalan    <= '0;
            deger1_r     <= '0;
            deger2_r     <= '0;
        end else begin
            if (kabul) begin
                deger1_r <= deger1_i;
                deger2_r <= deger2_i;
            end
            if (durum == DUZELT && !temizle_i && !ozel_r) begin
                onb_gecerli  <= 1'b1;
                onb_isaretli <= isaretli_r;
                onb_d1       <= deger1_r;
                onb_d2       <= deger2_r;
                onb_bolum    <= bolum_son;
                onb_kalan    <= kalan_son;
            end
        end
    end
`else
    assign isabet = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            kontrol_r <= BOLME_DIV;
            isaret1_r <= 1'b0;
            isaret2_r <= 1'b0;
            ozel_r    <= 1'b0;
            bolen_r   <= '0;
            kalan_r   <= '0;
            bolum_r   <= '0;
            sayac_r   <= '0;
            sonuc_o   <= '0;
            gecerli_o <= 1'b0;
        end else begin
            gecerli_o <= 1'b0;
            if (kabul) begin
                kontrol_r <= kontrol_i;
                isaret1_r <= deger1_i[XLEN-1];
                isaret2_r <= deger2_i[XLEN-1];
                bolen_r   <= mutlak2;
                sayac_r   <= SAYAC_YUK;
                ozel_r    <= sifira_bolme || tasma;
                if (sifira_bolme) begin
                    bolum_r <= '1;
                    kalan_r <= deger1_i;
                end else if (tasma) begin
                    bolum_r <= EN_KUCUK;
                    kalan_r <= '0;
                end else begin
                    bolum_r <= mutlak1;
                    kalan_r <= '0;
                end
            end else if (durum == BOL && !temizle_i) begin
                kalan_r <= fark[XLEN] ? kaydirilmis[XLEN-1:0] : fark[XLEN-1:0];
                bolum_r <= {bolum_r[XLEN-2:0], ~fark[XLEN]};
                sayac_r <= sayac_r - SAYAC_BIR;
            end else if (durum == DUZELT && !temizle_i) begin
                sonuc_o   <= bolum_sec_r ? bolum_son : kalan_son;
                gecerli_o <= 1'b1;
            end
`ifdef BOLME_ONBELLEK_EN
            if (durum == BOSTA && basla_i && !temizle_i && isabet) begin
                sonuc_o   <= (kontrol_i == BOLME_REM || kontrol_i == BOLME_REMU) ? onb_kalan : onb_bolum;
                gecerli_o <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_bolme_birimi.sv
// tb/tb_bolme_birimi.sv - scoreboard bench for bolme_birimi
module tb_bolme_birimi;
    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        basla_i = 1'b0;
    logic        temizle_i = 1'b0;
    logic [1:0]  kontrol_i = 2'b00;
    logic [31:0] deger1_i = '0;
    logic [31:0] deger2_i = '0;
    logic [31:0] sonuc_o;
    logic        mesgul_o;
    logic        gecerli_o;

    int errors = 0;
    int checks = 0;

`ifdef BOLME_ONBELLEK_EN
    localparam bit ONB = 1'b1;
`else
    localparam bit ONB = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        int          lat;
    } beklenen_t;

    beklenen_t   sb[$];
    bit          onb_v = 1'b0;
    bit          onb_s = 1'b0;
    logic [31:0] onb_a = '0;
    logic [31:0] onb_b = '0;

    bolme_birimi #(.XLEN(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .basla_i   (basla_i),
        .temizle_i (temizle_i),
        .kontrol_i (kontrol_i),
        .deger1_i  (deger1_i),
        .deger2_i  (deger2_i),
        .sonuc_o   (sonuc_o),
        .mesgul_o  (mesgul_o),
        .gecerli_o (gecerli_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa  = $signed(a);
            sb_ = $signed(b);
            return op[1] ? 32'(sa % sb_) : 32'(sa / sb_);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int gecikme(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bit s;
        s = ~op[0];
        if (ONB && onb_v && a == onb_a && b == onb_b && s == onb_s) return 1;
        if (b == 32'h0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
        return 34;
    endfunction

    // Starts one operation, pushes its expectation and waits (bounded) for gecerli_o.
    task automatic calistir(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] r, output int lat, output logic m1,
                            output logic mdone, output logic g0);
        beklenen_t e;
        @(negedge clk);
        g0        = gecerli_o;
        kontrol_i = op;
        deger1_i  = a;
        deger2_i  = b;
        basla_i   = 1'b1;
        e.res = model(op, a, b);
        e.lat = gecikme(op, a, b);
        sb.push_back(e);
        if (e.lat == 34) begin
            onb_v = 1'b1; onb_a = a; onb_b = b; onb_s = ~op[0];
        end
        r = '0; m1 = 1'b0; mdone = 1'b1; lat = 101;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            basla_i   = 1'b0;
            kontrol_i = 2'($urandom);
            deger1_i  = $urandom;
            deger2_i  = $urandom;
            if (i == 1) m1 = mesgul_o;
            if (gecerli_o) begin
                lat = i; r = sonuc_o; mdone = mesgul_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (sonuc_o !== 32'h0) begin errors++; $display("FAIL reset_sonuc got %h expected 0", sonuc_o); end
        checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL reset_mesgul got %b expected 0", mesgul_o); end
        checks++; if (gecerli_o !== 1'b0) begin errors++; $display("FAIL reset_gecerli got %b expected 0", gecerli_o); end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic test_div_rem();
        logic [1:0]  ops[9] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
        logic [31:0] as[9]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'h0, 32'h0, 32'h0};
        logic [31:0] bs[9]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd2, 32'h0, 32'h0, 32'h0};
        logic [31:0] r;
        logic        m1, md, g0;
        int          lat;
        beklenen_t   e;
        for (int i = 6; i < 9; i++) begin
            as[i] = $urandom;
            bs[i] = $urandom | 32'h1;
        end
        for (int i = 0; i < 9; i++) begin
            calistir(ops[i], as[i], bs[i], r, lat, m1, md, g0);
            e = sb.pop_front();
            checks++; if (r !== e.res) begin errors++; $display("FAIL div_sonuc[%0d] op=%0d %h/%h got %h expected %h", i, ops[i], as[i], bs[i], r, e.res); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL div_gecikme[%0d] got %0d expected %0d", i, lat, e.lat); end
            checks++; if (m1 !== (e.lat > 1)) begin errors++; $display("FAIL div_mesgul_ilk[%0d] got %b expected %b", i, m1, e.lat > 1); end
            checks++; if (md !== 1'b0) begin errors++; $display("FAIL div_mesgul_son[%0d] got %b expected 0", i, md); end
        end
    endtask

    task automatic test_special();
        logic [1:0]  ops[6] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b11};
        logic [31:0] as[6]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'h8000_0000};
        logic [31:0] bs[6]  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] r;
        logic        m1, md, g0;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 6; i++) begin
            calistir(ops[i], as[i], bs[i], r, lat, m1, md, g0);
            e = sb.pop_front();
            checks++; if (r !== e.res) begin errors++; $display("FAIL ozel_sonuc[%0d] got %h expected %h", i, r, e.res); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL ozel_gecikme[%0d] got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] onceki, r;
        logic        m1, md, g0;
        int          lat;
        beklenen_t   e;
        @(negedge clk);
        onceki    = sonuc_o;
        kontrol_i = 2'b00;
        deger1_i  = 32'd1234;
        deger2_i  = 32'd7;
        basla_i   = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); #1;
            basla_i = 1'b0;
        end
        @(negedge clk);
        temizle_i = 1'b1;
        @(posedge clk); #1;
        temizle_i = 1'b0;
        checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL temizle_mesgul got %b expected 0", mesgul_o); end
        checks++; if (gecerli_o !== 1'b0) begin errors++; $display("FAIL temizle_gecerli got %b expected 0", gecerli_o); end
        checks++; if (sonuc_o !== onceki) begin errors++; $display("FAIL temizle_sonuc got %h expected %h", sonuc_o, onceki); end
        calistir(2'b01, 32'd1000, 32'd10, r, lat, m1, md, g0);
        e = sb.pop_front();
        checks++; if (r !== e.res) begin errors++; $display("FAIL temizle_yeni_sonuc got %h expected %h", r, e.res); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL temizle_yeni_gecikme got %0d expected %0d", lat, e.lat); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[3] = '{2'b01, 2'b00, 2'b11};
        logic [31:0] as[3]  = '{32'd1000, 32'hFFFF_FC18, 32'd7};
        logic [31:0] bs[3]  = '{32'd3, 32'd3, 32'h0};
        logic [31:0] r;
        logic        m1, md, g0;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 3; i++) begin
            calistir(ops[i], as[i], bs[i], r, lat, m1, md, g0);
            e = sb.pop_front();
            if (i > 0) begin
                checks++; if (g0 !== 1'b1) begin errors++; $display("FAIL ardisik_gecerli[%0d] got %b expected 1", i, g0); end
            end
            checks++; if (r !== e.res) begin errors++; $display("FAIL ardisik_sonuc[%0d] got %h expected %h", i, r, e.res); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL ardisik_gecikme[%0d] got %0d expected %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_reset_mid();
        logic darbe;
        @(negedge clk);
        kontrol_i = 2'b00;
        deger1_i  = 32'd5000;
        deger2_i  = 32'd3;
        basla_i   = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk); #1;
            basla_i = 1'b0;
        end
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        onb_v = 1'b0;
        checks++; if (sonuc_o !== 32'h0) begin errors++; $display("FAIL ara_reset_sonuc got %h expected 0", sonuc_o); end
        checks++; if (mesgul_o !== 1'b0) begin errors++; $display("FAIL ara_reset_mesgul got %b expected 0", mesgul_o); end
        checks++; if (gecerli_o !== 1'b0) begin errors++; $display("FAIL ara_reset_gecerli got %b expected 0", gecerli_o); end
        @(negedge clk);
        rst_i = 1'b1;
        darbe = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (gecerli_o || mesgul_o) darbe = 1'b1;
        end
        checks++; if (darbe !== 1'b0) begin errors++; $display("FAIL ara_reset_darbe got %b expected 0", darbe); end
    endtask

    task automatic test_cache();
        logic [1:0]  ops[3] = '{2'b00, 2'b10, 2'b11};
        logic [31:0] r;
        logic        m1, md, g0;
        int          lat;
        beklenen_t   e;
        for (int i = 0; i < 3; i++) begin
            calistir(ops[i], 32'd100, 32'd7, r, lat, m1, md, g0);
            e = sb.pop_front();
            checks++; if (r !== e.res) begin errors++; $display("FAIL onbellek_sonuc[%0d] got %h expected %h", i, r, e.res); end
            checks++; if (lat != e.lat) begin errors++; $display("FAIL onbellek_gecikme[%0d] got %0d expected %0d", i, lat, e.lat); end
            checks++; if (m1 !== (e.lat > 1)) begin errors++; $display("FAIL onbellek_mesgul[%0d] got %b expected %b", i, m1, e.lat > 1); end
        end
    endtask

    initial begin
        test_reset();
        test_div_rem();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_cache();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_bos got %0d expected 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bolme_birimi.md
Name: bolme_birimi

Overview:
Iterative integer divider for the RV32M divide group (DIV, DIVU, REM, REMU). It sits in the execute stage beside the multiply unit and takes the same kind of operands and control. It is a multi-cycle radix-2 restoring divider with a start/busy/valid handshake toward the pipeline control. Special cases (divide-by-zero, signed overflow) are resolved early, following the RISC-V rules.

Parameters:
XLEN, 32, operand/result width; latency scales as XLEN+2.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-low reset
basla_i  input  1  start request; sampled only in BOSTA
temizle_i  input  1  pipeline flush; aborts any in-flight divide
kontrol_i  input  2  operation: `BOLME_DIV=2'b00, `BOLME_DIVU=2'b01, `BOLME_REM=2'b10, `BOLME_REMU=2'b11 (defined in tanimlamalar.vh)
deger1_i  input  XLEN  dividend
deger2_i  input  XLEN  divisor
sonuc_o  output  XLEN  registered result; holds its value until the next completion
mesgul_o  output  1  high while a divide is in flight
gecerli_o  output  1  one-cycle pulse: sonuc_o is valid

Behaviour:
- Reset (rst_i=0, async): state BOSTA, sonuc_o=0, mesgul_o=0, gecerli_o=0, counter=0, internal registers cleared.
- States:
  - BOSTA: idle.
  - BOL: one iteration per clock.
  - DUZELT: sign fix and result write.
- BOSTA, basla_i=1, temizle_i=0, at edge 1:
  - Latch the operation, the operand signs and the absolute values. |x| applies only for DIV/REM.
  - Load counter=XLEN, go to BOL, mesgul_o=1.
  - Exception: divisor==0 or signed overflow goes straight to DUZELT with the special result preloaded.
- BOL, each edge:
  - Shift {remainder, quotient} left by 1.
  - Trial subtract remainder - divisor, using XLEN+1 bits.
  - If non-negative: keep the difference and set quotient LSB=1.
  - Decrement counter. When counter reaches 0 after the last iteration, go to DUZELT.
- DUZELT, one edge:
  - Quotient is negated if the dividend and divisor signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - sonuc_o is the quotient (DIV/DIVU) or the remainder (REM/REMU).
  - gecerli_o=1 for the next cycle, mesgul_o=0, go to BOSTA.
- Latency:
  - Normal: gecerli_o is high in the cycle after edge XLEN+2 (edge 34 for XLEN=32), counting the edge that samples basla_i as edge 1.
  - Special cases: gecerli_o is high after edge 2.
- Special results:
  - Divide by zero: quotient=all ones, remainder=dividend (both signed and unsigned).
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- basla_i while mesgul_o=1 is ignored. basla_i in the same cycle that gecerli_o=1 is accepted (state is BOSTA).
- temizle_i=1:
  - Synchronous. The next state is BOSTA, mesgul_o=0, and no gecerli_o is produced. sonuc_o is unchanged.
  - temizle_i beats basla_i in the same cycle.
- Operand and kontrol_i inputs are sampled only at the start edge. Later changes have no effect.
- Reset mid-operation: immediate return to reset values. No pulse is produced.

Optional Feature:
BOLME_ONBELLEK_EN:
- When defined:
  - On every normal completion, store deger1, deger2, signedness, quotient and remainder.
  - A basla_i in BOSTA with the same operands and the same signedness is a hit. DIV/REM count as signed; DIVU/REMU count as unsigned.
  - On a hit, sonuc_o is loaded from the stored quotient or remainder at edge 1, gecerli_o is high after edge 1, mesgul_o stays 0, and the state stays BOSTA.
  - The stored entry is invalidated only by reset. temizle_i does not invalidate completed entries.
- When not defined: no storage is built, every request takes the full latency, and behaviour is otherwise identical.

Test Plan:
- DIV 100/7 -> sonuc_o=14, gecerli_o high after edge 34; REM 100/7 -> 2; mesgul_o high from after edge 1 through edge 34.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; REMU -> 1.
- DIVU 5/0 -> 0xFFFFFFFF after edge 2; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- Start DIV 100/7, assert temizle_i at edge 10 -> mesgul_o=0 next cycle, no gecerli_o, sonuc_o unchanged; a new basla_i accepted at edge 11 completes normally.
- Back-to-back: basla_i in the cycle gecerli_o=1 -> the second operation is accepted with no lost cycle. rst_i low at edge 20 -> all outputs 0 immediately.
- With BOLME_ONBELLEK_EN: DIV 100/7 (34 edges), then REM 100/7 -> 2 after edge 1 with mesgul_o=0; REMU 100/7 -> miss, 34 edges; without the macro, REM takes 34 edges.
